// File: rtl/b_rsp_if.sv
// Link between block a (sender) and block b (receive-side endpoint b_rsp).
// a drives words with a single-cycle strobe and receives one checksum pulse per accepted word.
interface b_rsp_if #(
    parameter int A_B_0 = 17
);
    // Strobe semantics: a word on a_b_0 is offered in every cycle where
    // a_b_1=1. There is no ready/backpressure, so the receiver takes it or
    // drops it and flags b_ovf. b_a_1 is a one-cycle valid pulse that
    // qualifies b_a_0. b_a_0 holds its value between pulses.
    logic [A_B_0:0] a_b_0;
    logic           a_b_1;
    logic [3:0]     b_a_0;
    logic           b_a_1;
    logic           b_ovf;
    logic           b_ovf_clr;

    modport master (
        output a_b_0, a_b_1, b_ovf_clr,
        input  b_a_0, b_a_1, b_ovf
    );

    modport slave (
        input  a_b_0, a_b_1, b_ovf_clr,
        output b_a_0, b_a_1, b_ovf
    );
endinterface

// File: rtl/b_rsp.sv
// b_rsp: receive-side endpoint of the a-to-b link.
// The block buffers strobed words in a small FIFO. Each word is then folded to a
// 4-bit nibble checksum, which is returned as a one-cycle pulse. After each pulse
// the block waits a programmable number of idle cycles.
// Optional feature macro: B_PARITY_EN. When this macro is defined, the MSB of
// each word is an even-parity bit. The response then becomes {parity_error, fold[2:0]}.
module b_rsp #(
    parameter int A_B_0      = 17,
    parameter int FIFO_DEPTH = 4,
    parameter int RSP_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    b_rsp_if.slave     bus,
    output logic [1:0] dbg_state
);
    localparam int          W        = A_B_0 + 1;
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]  GAP_LOAD = (RSP_GAP > 0) ? 4'(RSP_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [A_B_0:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop, drop;
    logic [A_B_0:0]  word_q;
    logic [3:0]      gap_q, gap_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q;
    logic            ovf_q;

    // A push is accepted while there is room. It is also accepted when full if
    // the FSM frees a slot in the same cycle. Otherwise the word is dropped.
    assign push = bus.a_b_1 && ((count < DEPTH_C) || pop);
    assign drop = bus.a_b_1 && !push;

    // FIFO storage: the data array needs no reset, because count decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.a_b_0;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the depth is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM next-state logic. The FSM pops in IDLE, and the gap counter holds the cycle for GAP.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: state_d = RESP;
            RESP: begin
                if (RSP_GAP > 0) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) state_d = IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, gap counter and the popped word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= 4'd0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            if (pop) word_q <= mem[rd_ptr];
        end
    end

`ifdef B_PARITY_EN
    localparam int NIBL = (A_B_0 + 3) / 4;
    logic [NIBL*4-1:0] low_ext;
    logic [2:0]        fold_low;

    // Fold only the payload bits. Only the low 3 fold bits are needed, because
    // the top response bit carries the parity error instead.
    always_comb begin
        low_ext            = '0;
        low_ext[A_B_0-1:0] = word_q[A_B_0-1:0];
        fold_low           = 3'd0;
        for (int i = 0; i < NIBL; i++) begin
            fold_low = fold_low ^ low_ext[i*4 +: 3];
        end
        code_d = {^word_q, fold_low};
    end
`else
    localparam int NIB = (W + 3) / 4;
    logic [NIB*4-1:0] word_ext;

    // Zero-extend the word to whole nibbles, then XOR all the nibbles together.
    always_comb begin
        word_ext        = '0;
        word_ext[W-1:0] = word_q;
        code_d          = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            code_d = code_d ^ word_ext[i*4 +: 4];
        end
    end
`endif

    // Response registers. The code is captured when the FSM leaves CALC, and the
    // pulse is high only while the FSM is in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == CALC);
            if (state_q == CALC) code_q <= code_d;
        end
    end

    // Sticky overflow flag. If a drop and a clear happen in the same cycle, the drop wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (bus.b_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.b_a_0 = code_q;
    assign bus.b_a_1 = valid_q;
    assign bus.b_ovf = ovf_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_b_rsp.sv
// Directed testbench for b_rsp: reset, checksum values, FIFO fill/drop,
// overflow clear priority, reset mid-operation and (optionally) parity mode.
module tb_b_rsp;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [3:0] exp_q[$];
    logic [3:0] got_code_q[$];
    int         got_cyc_q[$];

    b_rsp_if #(.A_B_0(17)) bus();

    b_rsp #(.A_B_0(17), .FIFO_DEPTH(4), .RSP_GAP(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: each cycle with b_a_1 high is recorded with its cycle number
    always @(negedge clk) begin
        if (bus.b_a_1 === 1'b1) begin
            got_code_q.push_back(bus.b_a_0);
            got_cyc_q.push_back(cyc);
        end
    end

    // One clock of stimulus; entered and left 1ns after a rising edge
    task automatic drive_cycle(input logic stb, input logic [17:0] w, input logic clr);
        bus.a_b_1     = stb;
        bus.a_b_0     = w;
        bus.b_ovf_clr = clr;
        @(posedge clk);
        #1;
        bus.a_b_1     = 1'b0;
        bus.b_ovf_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_monitor();
        got_code_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    // Compare recorded pulses against exp_q; first pulse at t0, then every 'period' cycles
    task automatic check_pulses(input string name, input int t0, input int period);
        logic [3:0] e;
        checks++;
        if (got_code_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s pulse_count got=%0d exp=%0d", name, got_code_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_code_q.size(); i++) begin
            e = exp_q[i];
            checks++;
            if (got_code_q[i] !== e) begin
                failures++;
                $display("FAIL %s code[%0d] got=%h exp=%h", name, i, got_code_q[i], e);
            end
            checks++;
            if (got_cyc_q[i] !== t0 + i * period) begin
                failures++;
                $display("FAIL %s cycle[%0d] got=%0d exp=%0d", name, i, got_cyc_q[i], t0 + i * period);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.a_b_0 = '0;
        bus.a_b_1 = 1'b0;
        bus.b_ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.b_a_0 !== 4'h0 || bus.b_a_1 !== 1'b0 || bus.b_ovf !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_values got code=%h valid=%b ovf=%b st=%0d exp 0/0/0/0",
                     bus.b_a_0, bus.b_a_1, bus.b_ovf, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_monitor();
    endtask

    task automatic test_single();
        int n;
        clear_monitor();
        drive_cycle(1'b1, 18'h31234, 1'b0);
        n = cyc;
        exp_q.push_back(4'h7);                 // 3^1^2^3^4
        idle(12);
        check_pulses("single", n + 2, 5);
        checks++;
        if (bus.b_a_0 !== 4'h7 || bus.b_ovf !== 1'b0) begin
            failures++;
            $display("FAIL single_hold got code=%h ovf=%b exp code=7 ovf=0", bus.b_a_0, bus.b_ovf);
        end
    endtask

    task automatic test_extremes();
        int n;
        clear_monitor();
        drive_cycle(1'b1, 18'h00000, 1'b0);
        n = cyc;
        idle(9);
        drive_cycle(1'b1, 18'h3FFFF, 1'b0);
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h3);                 // nibbles 3,F,F,F,F: the F's cancel in pairs
        idle(12);
        check_pulses("extremes", n + 2, 10);
    endtask

    task automatic test_back_to_back();
        int n;
        clear_monitor();
        drive_cycle(1'b1, 18'd1, 1'b0);
        n = cyc;
        for (int i = 2; i <= 6; i++) drive_cycle(1'b1, 18'(i), 1'b0);
        checks++;
        if (bus.b_ovf !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ovf got=%b exp=1", bus.b_ovf);
        end
        for (int i = 1; i <= 5; i++) exp_q.push_back(4'(i));
        idle(30);
        check_pulses("b2b", n + 2, 5);
    endtask

    task automatic test_ovf_clr();
        clear_monitor();
        drive_cycle(1'b0, 18'd0, 1'b1);
        checks++;
        if (bus.b_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_plain_clear got=%b exp=0", bus.b_ovf);
        end
        for (int i = 1; i <= 5; i++) drive_cycle(1'b1, 18'(i), 1'b0);
        drive_cycle(1'b1, 18'd6, 1'b1);        // dropped word and clear together
        checks++;
        if (bus.b_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins got=%b exp=1", bus.b_ovf);
        end
        drive_cycle(1'b0, 18'd0, 1'b1);
        checks++;
        if (bus.b_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear_after got=%b exp=0", bus.b_ovf);
        end
        idle(30);
        clear_monitor();
    endtask

    task automatic test_reset_mid();
        int n;
        clear_monitor();
        for (int i = 1; i <= 5; i++) drive_cycle(1'b1, 18'(i), 1'b0);
        idle(3);                               // word 2 now in RESP, words 3..5 buffered
        checks++;
        if (dbg_state !== 2'd2 || bus.b_a_1 !== 1'b1 || bus.b_a_0 !== 4'h2) begin
            failures++;
            $display("FAIL mid_in_resp got st=%0d valid=%b code=%h exp st=2 valid=1 code=2",
                     dbg_state, bus.b_a_1, bus.b_a_0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.b_a_1 !== 1'b0 || bus.b_a_0 !== 4'h0) begin
            failures++;
            $display("FAIL mid_async_reset got valid=%b code=%h exp valid=0 code=0", bus.b_a_1, bus.b_a_0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_monitor();
        idle(20);
        checks++;
        if (got_code_q.size() !== 0) begin
            failures++;
            $display("FAIL mid_no_stale_pulses got=%0d exp=0", got_code_q.size());
        end
        drive_cycle(1'b1, 18'h0000A, 1'b0);
        n = cyc;
        exp_q.push_back(4'hA);
        idle(10);
        check_pulses("mid_restart", n + 2, 5);
    endtask

`ifdef B_PARITY_EN
    task automatic test_parity();
        int n;
        clear_monitor();
        // 18'h31234: popcount 7 (odd) -> perr=1; low 17 bits 0x11234 fold to 4^3^2^1^1=5
        drive_cycle(1'b1, 18'h31234, 1'b0);
        n = cyc;
        exp_q.push_back(4'hD);
        idle(9);
        // 18'h11234: popcount 6 (even) -> perr=0; same payload fold 5
        drive_cycle(1'b1, 18'h11234, 1'b0);
        exp_q.push_back(4'h5);
        idle(12);
        check_pulses("parity", n + 2, 10);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_ovf_clr();
        test_reset_mid();
`ifdef B_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
